// File: rtl/work_serial_transmit_pkg.sv
// Shared constants and state encoding for the work-packet UART transmitter.
package work_serial_transmit_pkg;

    localparam int PACKET_BYTES = 84;
    localparam int FRAME_BITS   = 10;
    localparam int PACKET_BITS  = PACKET_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5
    } txState_e;

    function automatic int calcDiv(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

endpackage

// File: rtl/work_serial_transmit_if.sv
// Host-side bundle of the work packet request and the transmitter status lines.
interface work_serial_transmit_if;

    logic         start;
    logic [255:0] data1;
    logic [255:0] data2;
    logic [127:0] data3;
    logic [31:0]  target;
    logic         TxD;
    logic         busy;
    logic         done;

    modport master (
        output start, data1, data2, data3, target,
        input  TxD, busy, done
    );

    modport slave (
        input  start, data1, data2, data3, target,
        output TxD, busy, done
    );

endinterface

// File: rtl/work_serial_transmit_serial_byte_tx.sv
// Single UART frame sender: start bit, 8 data bits LSB first, stop bit, optional mark gap.
module serial_byte_tx
    import work_serial_transmit_pkg::*;
#(
    parameter int DIV      = 108,
    parameter int GAP_BITS = 0
) (
    input  logic       uart_clk,
    input  logic       reset,
    input  logic [7:0] i_byte,
    input  logic       i_send,
    output logic       o_byteBusy,
    output logic       o_frameEnd,
    output logic       o_txd
);

    localparam int               DIV_W      = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [3:0]       GAP_LAST   = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

    txState_e         r_state;
    txState_e         w_nextState;
    logic [DIV_W-1:0] r_divCnt;
    logic [DIV_W-1:0] w_divCnt;
    logic [3:0]       r_bitCnt;
    logic [3:0]       w_bitCnt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift;
    logic             w_tick;
    logic             w_frameEnd;
    logic             w_load;

    assign w_tick     = (r_divCnt == '0);
    assign o_byteBusy = (r_state != IDLE);
    assign o_frameEnd = w_frameEnd;

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_nextState;
            r_divCnt <= w_divCnt;
            r_bitCnt <= w_bitCnt;
            r_shift  <= w_shift;
        end
    end

    // A new frame may be loaded on the last cycle of the previous one so bytes run back-to-back.
    always_comb begin
        w_nextState = r_state;
        w_divCnt    = w_tick ? DIV_RELOAD : r_divCnt - 1'b1;
        w_bitCnt    = r_bitCnt;
        w_shift     = r_shift;
        w_frameEnd  = 1'b0;
        w_load      = 1'b0;
        o_txd       = 1'b1;

        case (r_state)
            IDLE: begin
                w_divCnt = DIV_RELOAD;
                w_load   = i_send;
            end
            START_BIT: begin
                o_txd = 1'b0;
                if (w_tick) begin
                    w_nextState = DATA;
                    w_bitCnt    = '0;
                end
            end
            DATA: begin
                o_txd = r_shift[0];
                if (w_tick) begin
                    w_shift  = {1'b0, r_shift[7:1]};
                    w_bitCnt = r_bitCnt + 4'd1;
                    if (r_bitCnt == 4'd7) begin
                        w_nextState = STOP_BIT;
                        w_bitCnt    = '0;
                    end
                end
            end
            STOP_BIT: begin
                if (w_tick) begin
                    if (GAP_BITS == 0) begin
                        w_frameEnd  = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = GAP;
                        w_bitCnt    = '0;
                    end
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_bitCnt = r_bitCnt + 4'd1;
                    if (r_bitCnt == GAP_LAST) begin
                        w_frameEnd  = 1'b1;
                        w_nextState = IDLE;
                        w_bitCnt    = '0;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_load || (w_frameEnd && i_send)) begin
            w_nextState = START_BIT;
            w_shift     = i_byte;
            w_divCnt    = DIV_RELOAD;
            w_bitCnt    = '0;
        end
    end

endmodule

// File: rtl/work_serial_transmit.sv
// Serialises one 84-byte work packet {target, data3, data2, data1}, least-significant byte first.
module work_serial_transmit
    import work_serial_transmit_pkg::*;
#(
    parameter int comm_clk_frequency = 12_500_000,
    parameter int baud_rate          = 115_200,
    parameter int GAP_BITS           = 0
) (
    input  logic                   uart_clk,
    input  logic                   reset,
    work_serial_transmit_if.slave  host
);

    localparam int         DIV       = calcDiv(comm_clk_frequency, baud_rate);
    localparam logic [6:0] LAST_BYTE = 7'(PACKET_BYTES - 1);

    if (DIV < 2) begin : g_divCheck
        $error("work_serial_transmit: bit period must be at least 2 clocks");
    end

    if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_gapCheck
        $error("work_serial_transmit: GAP_BITS must be within 0..15");
    end

    logic [PACKET_BITS-1:0] r_shift;
    logic [6:0]             r_byteIdx;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_lastFrame;
    logic                   w_nextByte;
    logic                   w_send;
    logic [7:0]             w_byte;
    logic                   w_byteBusy;
    logic                   w_frameEnd;
    logic                   w_txd;

    // The done cycle also blocks a new start, so back-to-back packets always see a done pulse.
    assign w_accept    = host.start && !r_busy && !r_done && !w_byteBusy;
    assign w_lastFrame = w_frameEnd && (r_byteIdx == LAST_BYTE);
    assign w_nextByte  = w_frameEnd && (r_byteIdx != LAST_BYTE);
    assign w_send      = w_accept || w_nextByte;
    assign w_byte      = w_accept ? host.data1[7:0] : r_shift[15:8];

    assign host.TxD  = w_txd;
    assign host.busy = r_busy;
    assign host.done = r_done;

    // Low byte of r_shift is the byte on the line; rotating keeps the next one at [15:8].
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_byteIdx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_lastFrame;
            if (w_accept) begin
                r_shift   <= {host.target, host.data3, host.data2, host.data1};
                r_byteIdx <= '0;
                r_busy    <= 1'b1;
            end else if (w_nextByte) begin
                r_shift   <= {r_shift[7:0], r_shift[PACKET_BITS-1:8]};
                r_byteIdx <= r_byteIdx + 7'd1;
            end else if (w_lastFrame) begin
                r_busy    <= 1'b0;
                r_byteIdx <= '0;
            end
        end
    end

    serial_byte_tx #(
        .DIV      (DIV),
        .GAP_BITS (GAP_BITS)
    ) u_byteTx (
        .uart_clk   (uart_clk),
        .reset      (reset),
        .i_byte     (w_byte),
        .i_send     (w_send),
        .o_byteBusy (w_byteBusy),
        .o_frameEnd (w_frameEnd),
        .o_txd      (w_txd)
    );

endmodule

// File: tb/tb_work_serial_transmit.sv
// Scoreboard bench: expected bytes queued at start, compared against a line decoder per DUT.
module tb_work_serial_transmit;
    import work_serial_transmit_pkg::*;

    logic         uart_clk = 1'b0;
    logic         reset    = 1'b0;
    logic [255:0] data1    = '0;
    logic [255:0] data2    = '0;
    logic [127:0] data3    = '0;
    logic [31:0]  target   = '0;
    logic [2:0]   startV   = '0;
    logic [2:0]   txdV;
    logic [2:0]   busyV;
    logic [2:0]   doneV;

    int         cycleCnt   = 0;
    int         checkCount = 0;
    int         errorCount = 0;
    int         doneCnt    [3] = '{0, 0, 0};
    int         acceptCyc  [2] = '{0, 0};
    int         frameNo    [2] = '{0, 0};
    int         decodedCnt [2] = '{0, 0};
    logic [7:0] lastByte   [2] = '{8'h00, 8'h00};
    bit   [1:0] monActive  = 2'b11;
    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];

    work_serial_transmit_if ifA ();
    work_serial_transmit_if ifB ();
    work_serial_transmit_if ifC ();

    assign ifA.start = startV[0];
    assign ifA.data1 = data1;
    assign ifA.data2 = data2;
    assign ifA.data3 = data3;
    assign ifA.target = target;
    assign ifB.start = startV[1];
    assign ifB.data1 = data1;
    assign ifB.data2 = data2;
    assign ifB.data3 = data3;
    assign ifB.target = target;
    assign ifC.start = startV[2];
    assign ifC.data1 = data1;
    assign ifC.data2 = data2;
    assign ifC.data3 = data3;
    assign ifC.target = target;
    assign txdV  = {ifC.TxD, ifB.TxD, ifA.TxD};
    assign busyV = {ifC.busy, ifB.busy, ifA.busy};
    assign doneV = {ifC.done, ifB.done, ifA.done};

    work_serial_transmit #(.comm_clk_frequency(8), .baud_rate(1), .GAP_BITS(0)) dutA (
        .uart_clk (uart_clk), .reset (reset), .host (ifA.slave));
    work_serial_transmit #(.comm_clk_frequency(8), .baud_rate(1), .GAP_BITS(2)) dutB (
        .uart_clk (uart_clk), .reset (reset), .host (ifB.slave));
    work_serial_transmit dutC (
        .uart_clk (uart_clk), .reset (reset), .host (ifC.slave));

    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cycleCnt <= cycleCnt + 1;

    always @(negedge uart_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (doneV[i] === 1'b1) doneCnt[i] <= doneCnt[i] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    task automatic randomizeData();
        for (int w = 0; w < 8; w++) begin
            data1[w*32 +: 32] = $urandom();
            data2[w*32 +: 32] = $urandom();
        end
        for (int w = 0; w < 4; w++) data3[w*32 +: 32] = $urandom();
        target = $urandom();
    endtask

    // Decodes frames exactly one bit period per bit and checks them against the expected queue.
    task automatic monitorLine(input int idx, input int div, input int gap);
        int         frameLen;
        int         startCyc;
        int         lastStart;
        int         qsize;
        logic [24:0] bits;
        logic [7:0] expByte;
        logic       v;
        bit         stable;
        bit         aborted;
        frameLen  = FRAME_BITS + gap;
        lastStart = 0;
        forever begin
            @(negedge uart_clk);
            if (monActive[idx] && txdV[idx] === 1'b0) begin
                startCyc = cycleCnt;
                stable   = 1'b1;
                aborted  = 1'b0;
                bits     = '1;
                for (int p = 0; p < frameLen; p++) begin
                    v = txdV[idx];
                    for (int c = 1; c < div; c++) begin
                        @(negedge uart_clk);
                        if (txdV[idx] !== v) stable = 1'b0;
                        if (!monActive[idx]) aborted = 1'b1;
                    end
                    bits[p] = v;
                    if (p < frameLen - 1) @(negedge uart_clk);
                end
                if (!aborted) begin
                    if (frameNo[idx] == 0) checkOutput("startLatency", startCyc - acceptCyc[idx], 0);
                    else checkOutput("frameSpacing", startCyc - lastStart, frameLen * div);
                    checkOutput("bitStable", stable, 1);
                    checkOutput("startBit", bits[0], 0);
                    checkOutput("stopBit", bits[9], 1);
                    for (int g = 0; g < gap; g++) checkOutput("gapMark", bits[10+g], 1);
                    qsize = (idx == 0) ? expQ0.size() : expQ1.size();
                    checkOutput("frameExpected", qsize != 0, 1);
                    if (qsize != 0) begin
                        if (idx == 0) expByte = expQ0.pop_front();
                        else expByte = expQ1.pop_front();
                        checkOutput("frameByte", bits[8:1], expByte);
                    end
                    lastByte[idx] = bits[8:1];
                    lastStart = startCyc;
                    frameNo[idx]++;
                    decodedCnt[idx]++;
                end
            end
        end
    endtask

    initial monitorLine(0, 8, 0);
    initial monitorLine(1, 8, 2);

    // Raises start at a negedge, queues the packet bytes, returns just after the accepting edge.
    task automatic applyStimulus(input int idx);
        logic [PACKET_BITS-1:0] pkt;
        pkt = {target, data3, data2, data1};
        @(negedge uart_clk);
        startV[idx] = 1'b1;
        if (idx < 2) begin
            frameNo[idx] = 0;
            for (int b = 0; b < PACKET_BYTES; b++) begin
                if (idx == 0) expQ0.push_back(pkt[b*8 +: 8]);
                else expQ1.push_back(pkt[b*8 +: 8]);
            end
        end
        @(posedge uart_clk);
        #1;
        if (idx < 2) acceptCyc[idx] = cycleCnt;
    endtask

    task automatic waitDone(input int idx, input int expBusy);
        int busyCycles;
        bit seen;
        busyCycles = 0;
        seen       = 1'b0;
        for (int c = 0; c < expBusy + 50 && !seen; c++) begin
            @(negedge uart_clk);
            if (doneV[idx] === 1'b1) begin
                seen = 1'b1;
                checkOutput("busyAtDone", busyV[idx], 0);
            end else if (busyV[idx] === 1'b1) begin
                busyCycles++;
            end
        end
        checkOutput("doneSeen", seen, 1);
        checkOutput("busyCycles", busyCycles, expBusy);
    endtask

    task automatic runPacket(input int idx, input int expBusy, input int holdCycles, input int restartAt);
        int doneBefore;
        int decodedBefore;
        doneBefore    = doneCnt[idx];
        decodedBefore = decodedCnt[idx];
        applyStimulus(idx);
        fork
            waitDone(idx, expBusy);
            begin
                if (holdCycles > 1) begin
                    repeat (holdCycles - 1) @(posedge uart_clk);
                    #1;
                end
                startV[idx] = 1'b0;
                if (restartAt > 0) begin
                    repeat (restartAt) @(negedge uart_clk);
                    randomizeData();
                    startV[idx] = 1'b1;
                    repeat (2) @(negedge uart_clk);
                    startV[idx] = 1'b0;
                end
            end
        join
        repeat (5) @(negedge uart_clk);
        checkOutput("donePulses", doneCnt[idx] - doneBefore, 1);
        checkOutput("framesDecoded", decodedCnt[idx] - decodedBefore, PACKET_BYTES);
        checkOutput("queueDrained", (idx == 0) ? expQ0.size() : expQ1.size(), 0);
    endtask

    initial begin
        int doneBefore;
        #1 reset = 1'b1;
        repeat (3) @(negedge uart_clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rstTxD", txdV[i], 1);
            checkOutput("rstBusy", busyV[i], 0);
            checkOutput("rstDone", doneV[i], 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge uart_clk);

        $display("[TB] single set bit in data1");
        data1 = 256'h01;
        runPacket(0, 6720, 1, 0);

        $display("[TB] random packet, target 0xA5000000, start retried mid-packet");
        randomizeData();
        target = 32'hA500_0000;
        runPacket(0, 6720, 1, 100);
        checkOutput("finalByte", lastByte[0], 8'hA5);

        $display("[TB] new packet after done, start held three cycles");
        runPacket(0, 6720, 3, 0);

        $display("[TB] reset during byte 40");
        randomizeData();
        doneBefore = doneCnt[0];
        applyStimulus(0);
        startV[0] = 1'b0;
        repeat (40 * 80 + 3) @(negedge uart_clk);
        checkOutput("preResetTxD", txdV[0], 0);
        checkOutput("preResetBusy", busyV[0], 1);
        monActive[0] = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstTxD", txdV[0], 1);
        checkOutput("asyncRstBusy", busyV[0], 0);
        repeat (2) @(negedge uart_clk);
        reset = 1'b0;
        expQ0.delete();
        repeat (150) @(negedge uart_clk);
        checkOutput("noDoneAfterReset", doneCnt[0] - doneBefore, 0);
        checkOutput("idleAfterReset", txdV[0], 1);
        monActive[0] = 1'b1;
        randomizeData();
        runPacket(0, 6720, 1, 0);

        $display("[TB] two mark bits of gap after every frame");
        randomizeData();
        runPacket(1, 8064, 1, 0);

        $display("[TB] default divider bit period");
        data1  = 256'h55;
        data2  = '0;
        data3  = '0;
        target = '0;
        applyStimulus(2);
        startV[2] = 1'b0;
        @(negedge uart_clk);
        for (int r = 0; r < 9; r++) begin
            int   runLen;
            logic lvl;
            runLen = 0;
            lvl    = r[0];
            while (txdV[2] === lvl && runLen < 300) begin
                runLen++;
                @(negedge uart_clk);
            end
            checkOutput("bitPeriod", runLen, 108);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
